roll_uart_tx: RTL

- Downstream consumer of the dice-roll custom instruction's result.
- Accepts 7-bit roll values (0..127, covers D2..D100) through a valid strobe and buffers them in a small FIFO.
- Converts each value to ASCII decimal (no leading zeros), terminated by CR LF.
- Shifts the characters out on a single UART TX line (8N1 by default) for host-side logging of roll distributions.

---
 rtl/roll_uart_tx_if.sv | 21 ++
 rtl/roll_uart_tx.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/roll_uart_tx_if.sv
// rtl/roll_uart_tx_if.sv - roll input strobe and UART/FIFO status bundle for roll_uart_tx
interface roll_uart_tx_if;
  logic       i_roll_valid;
  logic [6:0] i_roll;
  logic       i_clr_ovf;
  logic       o_tx;
  logic       o_busy;
  logic       o_full;
  logic       o_empty;
  logic       o_overflow;

  modport master (
    output i_roll_valid, i_roll, i_clr_ovf,
    input  o_tx, o_busy, o_full, o_empty, o_overflow
  );

  modport slave (
    input  i_roll_valid, i_roll, i_clr_ovf,
    output o_tx, o_busy, o_full, o_empty, o_overflow
  );
endinterface

// File: rtl/roll_uart_tx.sv
// rtl/roll_uart_tx.sv - buffers 7-bit rolls, sends each as ASCII decimal + CR LF on a UART line
// 8N1 by default; defining ROLL_TX_PARITY_EN switches to 8E1 framing.
module roll_uart_tx #(
  parameter int CLK_HZ     = 50000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 4
) (
  input logic           clk,
  input logic           reset,
  roll_uart_tx_if.slave bus
);
  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int BCW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int AW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [BCW-1:0] BAUD_LAST = BCW'(CLKS_PER_BIT - 1);
  localparam logic [AW:0]    DEPTH_CNT = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE, LOAD, START, DATA, STOP, NEXT
`ifdef ROLL_TX_PARITY_EN
    , PARITY
`endif
  } state_t;

  logic [6:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     count, count_next;
  logic            full_reg, empty_reg, ovf_reg;
  logic            push, drop, pop;

  state_t          state, state_next;
  logic            tx_reg, tx_next;
  logic [BCW-1:0]  baud_cnt;
  logic            bit_done;
  logic [2:0]      bit_cnt;
  logic [7:0]      shift_reg;
  logic [4:0][7:0] char_buf;
  logic [2:0]      char_idx, char_last, next_idx;
  logic [6:0]      roll_reg;
`ifdef ROLL_TX_PARITY_EN
  logic            parity_reg;
`endif

  // Full is judged on the registered flag only, so a same-cycle pop never rescues a push.
  assign push = bus.i_roll_valid && !full_reg;
  assign drop = bus.i_roll_valid && full_reg;

  always_comb begin
    count_next = count;
    if (push && !pop)
      count_next = count + 1'b1;
    else if (pop && !push)
      count_next = count - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= bus.i_roll;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      full_reg  <= 1'b0;
      empty_reg <= 1'b1;
      ovf_reg   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count     <= count_next;
      full_reg  <= (count_next == DEPTH_CNT);
      empty_reg <= (count_next == '0);
      if (drop)
        ovf_reg <= 1'b1;
      else if (bus.i_clr_ovf)
        ovf_reg <= 1'b0;
    end
  end

  // Decimal split of the popped roll and the resulting character list.
  logic       hund;
  logic [6:0] rem1;
  logic [3:0] tens, units;
  logic [4:0][7:0] chars;
  logic [2:0] last_idx;

  always_comb begin
    hund = (roll_reg >= 7'd100);
    rem1 = hund ? (roll_reg - 7'd100) : roll_reg;
    tens = 4'd0;
    for (int k = 1; k <= 9; k++)
      if (rem1 >= 7'(10 * k)) tens = 4'(k);
    units = 4'(rem1 - (7'(tens) * 7'd10));
    chars = {5{8'h0A}};
    if (hund) begin
      chars[0] = 8'h31;
      chars[1] = {4'h3, tens};
      chars[2] = {4'h3, units};
      chars[3] = 8'h0D;
      chars[4] = 8'h0A;
      last_idx = 3'd4;
    end else if (tens != 4'd0) begin
      chars[0] = {4'h3, tens};
      chars[1] = {4'h3, units};
      chars[2] = 8'h0D;
      chars[3] = 8'h0A;
      last_idx = 3'd3;
    end else begin
      chars[0] = {4'h3, units};
      chars[1] = 8'h0D;
      chars[2] = 8'h0A;
      last_idx = 3'd2;
    end
  end

  assign bit_done = (baud_cnt == BAUD_LAST);
  assign next_idx = char_idx + 3'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_next;
  end

  // tx_next reflects the current state and is registered, so the line lags the FSM by one clock.
  always_comb begin
    state_next = state;
    tx_next    = 1'b1;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (!empty_reg) begin
          pop        = 1'b1;
          state_next = LOAD;
        end
      end
      LOAD: state_next = START;
      START: begin
        tx_next = 1'b0;
        if (bit_done) state_next = DATA;
      end
      DATA: begin
        tx_next = shift_reg[0];
`ifdef ROLL_TX_PARITY_EN
        if (bit_done && bit_cnt == 3'd7) state_next = PARITY;
`else
        if (bit_done && bit_cnt == 3'd7) state_next = STOP;
`endif
      end
`ifdef ROLL_TX_PARITY_EN
      PARITY: begin
        tx_next = parity_reg;
        if (bit_done) state_next = STOP;
      end
`endif
      STOP: begin
        if (bit_done) state_next = NEXT;
      end
      NEXT: state_next = (char_idx != char_last) ? START : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_reg    <= 1'b1;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      char_buf  <= '0;
      char_idx  <= '0;
      char_last <= '0;
      roll_reg  <= '0;
`ifdef ROLL_TX_PARITY_EN
      parity_reg <= 1'b0;
`endif
    end else begin
      tx_reg <= tx_next;
      if (pop) roll_reg <= mem[rd_ptr];
      case (state)
        LOAD: begin
          char_buf  <= chars;
          shift_reg <= chars[0];
          char_idx  <= 3'd0;
          char_last <= last_idx;
          baud_cnt  <= '0;
          bit_cnt   <= '0;
`ifdef ROLL_TX_PARITY_EN
          parity_reg <= ^chars[0];
`endif
        end
        DATA: begin
          baud_cnt <= bit_done ? '0 : baud_cnt + 1'b1;
          if (bit_done) begin
            shift_reg <= {1'b0, shift_reg[7:1]};
            bit_cnt   <= bit_cnt + 3'd1;
          end
        end
`ifdef ROLL_TX_PARITY_EN
        PARITY: baud_cnt <= bit_done ? '0 : baud_cnt + 1'b1;
`endif
        START, STOP: baud_cnt <= bit_done ? '0 : baud_cnt + 1'b1;
        NEXT: begin
          if (char_idx != char_last) begin
            char_idx  <= next_idx;
            shift_reg <= char_buf[next_idx];
`ifdef ROLL_TX_PARITY_EN
            parity_reg <= ^char_buf[next_idx];
`endif
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.o_tx       = tx_reg;
  assign bus.o_busy     = (state != IDLE);
  assign bus.o_full     = full_reg;
  assign bus.o_empty    = empty_reg;
  assign bus.o_overflow = ovf_reg;
endmodule
